// File: rtl/uart_echo_buffer_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_echo_buffer_if                                             |
// | Purpose  : Bundles the serial pins, send request and status signals of     |
// |            uart_echo_buffer.                                               |
// | Ports    : rx_line, send, send_all   -> into the echo buffer               |
// |            tx_line, tx_busy, count, rx_err_parity, rx_err_frame, overflow  |
// |                                       <- out of the echo buffer            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface uart_echo_buffer_if #(
  parameter int DEPTH = 16
) ();
  logic                       rx_line;
  logic                       send;
  logic                       send_all;
  logic                       tx_line;
  logic                       tx_busy;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       rx_err_parity;
  logic                       rx_err_frame;
  logic                       overflow;

  // master: the board side driving requests and watching status
  modport master (
    output rx_line, send, send_all,
    input  tx_line, tx_busy, count, rx_err_parity, rx_err_frame, overflow
  );

  // slave: the echo buffer itself
  modport slave (
    input  rx_line, send, send_all,
    output tx_line, tx_busy, count, rx_err_parity, rx_err_frame, overflow
  );
endinterface
`default_nettype wire

// File: rtl/uart_echo_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_echo_buffer                                                |
// | Purpose  : UART receiver feeding a DEPTH-entry FIFO and a transmitter that |
// |            echoes one byte, or drains the whole queue, on each send pulse. |
// | Ports    : clk, rst_n (async, active low)                                  |
// |            bus.rx_line  serial in (synchronised here)                      |
// |            bus.send / bus.send_all  transmit request and drain select      |
// |            bus.tx_line / bus.tx_busy  serial out and frame-active flag     |
// |            bus.count    FIFO occupancy                                     |
// |            bus.rx_err_parity / rx_err_frame / overflow  1-cycle pulses     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_echo_buffer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_echo_buffer_if.slave  bus
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DBIT = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_SBIT = 4'(STOP_BITS - 1);
  localparam logic          HAS_PAR   = (PARITY != 0);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  // ---------------- input synchroniser ----------------
  logic sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.rx_line;
      sync2_q <= sync1_q;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 push_q, push_d;
  logic                 err_par_q, err_par_d;
  logic                 err_frm_q, err_frm_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    push_d     = 1'b0;
    err_par_d  = 1'b0;
    err_frm_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!sync2_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = sync2_q ? RX_IDLE : RX_DATA;   // high at mid-start is a glitch
      end
      RX_DATA: if (rx_cnt_q == FULL_M1) begin
        rx_cnt_d   = '0;
        rx_shift_d = {sync2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + 1'b1;
        if (rx_bit_q == LAST_DBIT) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_cnt_q == FULL_M1) begin
        rx_cnt_d   = '0;
        rx_par_d   = sync2_q;
        rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == FULL_M1) begin
        rx_cnt_d = '0;
        if (!sync2_q) begin
          // frame error wins over parity; wait out the low line before re-arming
          err_frm_d  = 1'b1;
          rx_state_d = RX_BREAK;
        end else begin
          if (HAS_PAR && (((^rx_shift_q) ^ rx_par_q) != PAR_ODD)) err_par_d = 1'b1;
          else push_d = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      RX_BREAK: begin
        rx_cnt_d = '0;
        if (sync2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      push_q     <= 1'b0;
      err_par_q  <= 1'b0;
      err_frm_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      push_q     <= push_d;
      err_par_q  <= err_par_d;
      err_frm_q  <= err_frm_d;
    end
  end

  // ---------------- FIFO ----------------
  // rx_shift_q is untouched while RX sits in IDLE, so it still holds the byte
  // during the push cycle.
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [CNTW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic                 pop, full, push_ok;
  logic [DATA_BITS-1:0] head;

  assign count   = wptr_q - rptr_q;
  assign full    = (count == CNTW'(DEPTH));
  assign push_ok = push_q && (!full || pop);
  assign head    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + CNTW'(push_ok);
    rptr_d = rptr_q + CNTW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= rx_shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_busy_q, tx_busy_d;
  logic                 drain_q, drain_d;
  logic                 start_frame;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q + 1'b1;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    tx_par_d    = tx_par_q;
    tx_line_d   = tx_line_q;
    tx_busy_d   = tx_busy_q;
    drain_d     = drain_q;
    start_frame = 1'b0;
    pop         = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (bus.send && (count != '0)) begin
          start_frame = 1'b1;
          drain_d     = bus.send_all;
        end
      end
      TX_START: if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == LAST_DBIT) begin
          tx_bit_d = '0;
          if (HAS_PAR) begin
            tx_line_d  = tx_par_q;
            tx_state_d = TX_PARITY;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          tx_line_d  = tx_shift_q[1];
        end
      end
      TX_PARITY: if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_line_d  = 1'b1;
        tx_state_d = TX_STOP;
      end
      TX_STOP: if (tx_cnt_q == FULL_M1) begin
        tx_cnt_d = '0;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == LAST_SBIT) begin
          if (drain_q && (count != '0)) begin
            start_frame = 1'b1;               // back-to-back, no idle gap
          end else begin
            drain_d    = 1'b0;
            tx_busy_d  = 1'b0;
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    if (start_frame) begin
      pop        = 1'b1;
      tx_shift_d = head;
      tx_par_d   = (^head) ^ PAR_ODD;
      tx_cnt_d   = '0;
      tx_line_d  = 1'b0;
      tx_busy_d  = 1'b1;
      tx_state_d = TX_START;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_busy_q  <= 1'b0;
      drain_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
      tx_busy_q  <= tx_busy_d;
      drain_q    <= drain_d;
    end
  end

  // ---------------- outputs ----------------
  assign bus.tx_line       = tx_line_q;
  assign bus.tx_busy       = tx_busy_q;
  assign bus.count         = count;
  assign bus.rx_err_parity = err_par_q;
  assign bus.rx_err_frame  = err_frm_q;
  // a simultaneous pop frees the slot, so only a push into a still-full FIFO drops
  assign bus.overflow      = push_q && full && !pop;

endmodule
`default_nettype wire

// File: doc/uart_echo_buffer.md
# uart_echo_buffer

Parametrised UART echo engine that supersedes the single-register receive/transmit path of the board top level. Serial frames received on `rx_line` are checked and queued in a DEPTH-entry FIFO; a debounced `send` pulse transmits the oldest byte or, in drain mode, the whole queue back-to-back on `tx_line`. Frame format (data bits, parity, stop bits) and baud divisor are compile-time parameters. It sits between the debouncer output and the board UART pins.

## Interface

- `CLKS_PER_BIT`, 868, clock cycles per bit (115200 baud at 100 MHz); minimum 4.
- `DATA_BITS`, 8, payload bits per frame; 5 to 9.
- `PARITY`, 0, 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, 1 or 2; RX checks only the first stop bit.
- `DEPTH`, 16, FIFO entries; power of two, at least 2.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_line`  in  1  asynchronous serial input; synchronised internally by 2 flip-flops.
- `send`  in  1  single-cycle pulse, already debounced upstream; requests transmission.
- `send_all`  in  1  level, sampled with `send`; 1 selects drain mode.
- `tx_line`  out  1  serial output; idles high.
- `tx_busy`  out  1  high while a frame is on `tx_line`.
- `count`  out  $clog2(DEPTH+1)  FIFO occupancy.
- `rx_err_parity`  out  1  1-cycle pulse when a frame is discarded for bad parity.
- `rx_err_frame`  out  1  1-cycle pulse when a frame is discarded for a low stop bit.
- `overflow`  out  1  1-cycle pulse when a good frame is dropped because the FIFO is full.

## Operation

**Reset (asserted, asynchronous)**
- `tx_line` = 1.
- `tx_busy`, `count`, all pulse outputs, and the drain flag = 0.
- FIFO is emptied; both FSMs go to IDLE.
- Applies mid-frame: a partial RX frame is discarded and a TX frame is truncated with the line high.

**RX FSM (IDLE, START, DATA, PARITY, STOP, BREAK)**
- IDLE → START when the synchronised line reads 0.
- START: after CLKS_PER_BIT/2 cycles, resample.
  - Line 1: treat as a glitch, return to IDLE with nothing logged.
  - Line 0: go to DATA.
- DATA: sample every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples.
- PARITY: entered only if PARITY≠0; one sample.
- STOP: one sample.
  - Stop = 0: pulse `rx_err_frame`, discard the byte, go to BREAK. BREAK waits for the line to read 1, then returns to IDLE.
  - Stop = 1 with a parity mismatch: pulse `rx_err_parity`, discard, return to IDLE.
  - Otherwise push to the FIFO. If the FIFO is full, pulse `overflow` and leave contents unchanged.
- Frame error takes priority over parity error; only one error pulse is raised per frame.

**FIFO**
- Circular buffer, DATA_BITS wide, with read/write pointers one bit wider than the address.
- Push and pop in the same cycle: both happen and `count` is unchanged. When full, a simultaneous pop lets the push succeed with no overflow.
- Pop when empty never happens; TX gates it.

**TX FSM (IDLE, START, DATA, PARITY, STOP)**
- Frame order: start bit 0, DATA_BITS LSB first, optional parity, STOP_BITS stop bits of 1.
- Parity bit: even parity is the XOR of the data bits; odd parity is its inverse.
- In IDLE, `send` with `count`>0 pops the head and starts a frame. `send` with `count`=0 is ignored.
- `send` while `tx_busy`=1 is ignored: no queueing and the mode is not changed.
- If `send_all`=1 at the accepted `send`, the drain flag is set. At the end of each frame, if drain=1 and `count`>0, pop and start the next frame immediately. Otherwise clear drain and go to IDLE.
- Bytes received during a drain are included in that drain.

## Timing

- Frame length F = CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- TX:
  - `send` accepted in cycle N: pop in N; `tx_line` falls and `tx_busy` rises in N+1.
  - `tx_busy` falls in N+1+F, unless draining.
  - In drain mode the next start bit begins in the cycle right after the last stop cycle; no idle gap, and `tx_busy` stays high.
- RX:
  - Let E be the first cycle the synchronised line reads 0. Bit k (start = 0) is sampled at E + CLKS_PER_BIT/2 + k × CLKS_PER_BIT.
  - The push and any error pulse occur in the cycle after the stop sample. `count` updates in the cycle after the push.
- `rx_line` to synchroniser output: 2 cycles.

## Test plan

Use CLKS_PER_BIT=16, DATA_BITS=8, PARITY=2, STOP_BITS=1, DEPTH=4 unless stated.

1. Receive 0xA5 with a correct even-parity bit of 0, then pulse `send` with `send_all`=0 → `count` goes 0→1→0; `tx_line` carries 0,1,0,1,0,0,1,0,1,0,1 with 16 cycles per bit; `tx_busy` is high for 176 cycles.
2. Receive 0x3C with parity bit 1, then 0x3C with stop bit 0 → `rx_err_parity` pulses once, then `rx_err_frame` pulses once; `count` stays 0. The next valid frame is accepted only after the line returns high.
3. Receive 5 valid bytes 0x01..0x05 → `count` = 4 and `overflow` pulses exactly once, on the fifth. A drain outputs 0x01..0x04 in order.
4. Pulse `send` with `send_all`=1 and `count`=3 → 3 frames back-to-back with `tx_busy` continuously high for 528 cycles; then `count`=0 and drain is clear. A `send` pulse mid-drain has no effect.
5. Hold `rx_line` low for 7 cycles, then high → no push and no error pulse (glitch rejected).
6. Assert `rst_n` low during TX bit 3 with `count`=2 → `tx_line`=1, `tx_busy`=0, `count`=0 asynchronously. After release, a `send` pulse is ignored.
